resp_gen: RTL and testbench

RESP_GEN -- requirements
Module: resp_gen

---
 rtl/resp_gen.sv | 130 +++++++++++++
 tb/tb_resp_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/resp_gen.sv
// Purpose: merges single-character echoes with fixed "-OK", "-ERR" and "-XXXX" hex responses into one character FIFO write stream.
// Latency: echo is written 1 cycle after send_char_val; a response starts 2 cycles after send_resp_val, and done pulses the cycle after its last write.
// Backpressure: response characters wait while char_fifo_full or an echo is present; echoes are always written, relying on the FIFO's early full.
module resp_gen #(
    parameter int EOL_CRLF = 1
) (
    input  logic        clk_rx,
    input  logic        rst_clk_rx,
    input  logic        send_char_val,
    input  logic [7:0]  send_char,
    input  logic        send_resp_val,
    input  logic [1:0]  send_resp_type,
    input  logic [15:0] send_resp_data,
    output logic        send_resp_done,
    input  logic        char_fifo_full,
    output logic [7:0]  char_fifo_din,
    output logic        char_fifo_wr_en
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SEND     = 3'd2,
        DONE     = 3'd3,
        WAIT_CLR = 3'd4
    } state_t;

    localparam int EOL_LEN = (EOL_CRLF != 0) ? 2 : 1;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  char_idx;
    logic [1:0]  type_lat;
    logic [15:0] data_lat;
    logic [2:0]  body_len;
    logic [2:0]  last_idx;
    logic [7:0]  resp_chr;
    logic [3:0]  nibble;
    logic        issue;

    // ASCII for one hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'
    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Select the response character at the current index from the latched type/data
    always_comb begin
        body_len = 3'd4;
        nibble   = data_lat[3:0];
        resp_chr = 8'h0A;
        case (type_lat)
            2'b00:   body_len = 3'd3;
            2'b10:   body_len = 3'd5;
            default: body_len = 3'd4;
        endcase
        last_idx = body_len + 3'(EOL_LEN - 1);
        case (char_idx)
            3'd1:    nibble = data_lat[15:12];
            3'd2:    nibble = data_lat[11:8];
            3'd3:    nibble = data_lat[7:4];
            default: nibble = data_lat[3:0];
        endcase
        if (char_idx == 3'd0) begin
            resp_chr = 8'h2D;
        end else if (char_idx < body_len) begin
            case (type_lat)
                2'b00:   resp_chr = (char_idx == 3'd1) ? 8'h4F : 8'h4B;
                2'b10:   resp_chr = hex_chr(nibble);
                default: resp_chr = (char_idx == 3'd1) ? 8'h45 : 8'h52;
            endcase
        end else if ((EOL_CRLF != 0) && (char_idx == body_len)) begin
            resp_chr = 8'h0D;
        end else begin
            resp_chr = 8'h0A;
        end
    end

    // Next-state logic; a response character is issued only on a cycle free of echo and full
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:     if (send_resp_val) state_nxt = LOAD;
            LOAD:     state_nxt = SEND;
            SEND: begin
                issue = !send_char_val && !char_fifo_full;
                if (issue && (char_idx == last_idx)) state_nxt = DONE;
            end
            DONE:     state_nxt = WAIT_CLR;
            WAIT_CLR: if (!send_resp_val) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) state <= IDLE;
        else            state <= state_nxt;
    end

    // Request latch and character index; inputs are ignored once the request is latched
    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            type_lat <= 2'b00;
            data_lat <= 16'h0000;
            char_idx <= 3'd0;
        end else if (state == LOAD) begin
            type_lat <= send_resp_type;
            data_lat <= send_resp_data;
            char_idx <= 3'd0;
        end else if (issue) begin
            char_idx <= char_idx + 3'd1;
        end
    end

    // Registered FIFO write port and done pulse; echo wins the write slot
    always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
        if (rst_clk_rx) begin
            char_fifo_wr_en <= 1'b0;
            char_fifo_din   <= 8'h00;
            send_resp_done  <= 1'b0;
        end else begin
            char_fifo_wr_en <= send_char_val || issue;
            if (send_char_val)  char_fifo_din <= send_char;
            else if (issue)     char_fifo_din <= resp_chr;
            send_resp_done  <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_resp_gen.sv
// Purpose: randomized and directed checking of resp_gen against a string-level model of the write stream.
// Latency: model expects each echo one cycle after its pulse and response characters in string order.
// Backpressure: model forbids a response write following a full or echo cycle.
module tb_resp_gen;

    localparam int EOL_CRLF = 1;

    logic        clk_rx = 1'b0;
    logic        rst_clk_rx;
    logic        send_char_val;
    logic [7:0]  send_char;
    logic        send_resp_val;
    logic [1:0]  send_resp_type;
    logic [15:0] send_resp_data;
    logic        send_resp_done;
    logic        char_fifo_full;
    logic [7:0]  char_fifo_din;
    logic        char_fifo_wr_en;

    typedef logic [7:0] byte_q_t[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = 0;

    logic [7:0] resp_q[$];
    logic [7:0] wlog[$];
    int         wcyc[$];
    bit         resp_active = 0;
    bit         prev_echo   = 0;
    bit         prev_full   = 0;
    logic [7:0] prev_chr    = 8'h00;

    resp_gen #(.EOL_CRLF(EOL_CRLF)) dut (
        .clk_rx          (clk_rx),
        .rst_clk_rx      (rst_clk_rx),
        .send_char_val   (send_char_val),
        .send_char       (send_char),
        .send_resp_val   (send_resp_val),
        .send_resp_type  (send_resp_type),
        .send_resp_data  (send_resp_data),
        .send_resp_done  (send_resp_done),
        .char_fifo_full  (char_fifo_full),
        .char_fifo_din   (char_fifo_din),
        .char_fifo_wr_en (char_fifo_wr_en)
    );

    always #5 clk_rx = ~clk_rx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected response string from the type/data rules
    task automatic push_expected(input logic [1:0] t, input logic [15:0] d);
        logic [3:0] nib;
        resp_q.push_back(8'h2D);
        case (t)
            2'b00: begin resp_q.push_back(8'h4F); resp_q.push_back(8'h4B); end
            2'b10: begin
                for (int i = 3; i >= 0; i--) begin
                    nib = d[i*4 +: 4];
                    resp_q.push_back((nib < 10) ? 8'(8'h30 + nib) : 8'(8'h41 + nib - 10));
                end
            end
            default: begin resp_q.push_back(8'h45); resp_q.push_back(8'h52); resp_q.push_back(8'h52); end
        endcase
        if (EOL_CRLF != 0) resp_q.push_back(8'h0D);
        resp_q.push_back(8'h0A);
        resp_active = 1;
    endtask

    // Compare process: every write is either last cycle's echo or the next expected response character
    always @(negedge clk_rx) begin
        cyc++;
        if (rst_clk_rx) begin
            chk("rst_wr_en", char_fifo_wr_en, 0);
            chk("rst_din", char_fifo_din, 8'h00);
            chk("rst_done", send_resp_done, 0);
            resp_q.delete();
            resp_active = 0;
            prev_echo = 0;
            prev_full = 0;
        end else begin
            if (char_fifo_wr_en) begin
                wlog.push_back(char_fifo_din);
                wcyc.push_back(cyc);
            end
            if (prev_echo) begin
                chk("echo_wr_en", char_fifo_wr_en, 1);
                chk("echo_din", char_fifo_din, prev_chr);
            end else if (char_fifo_wr_en) begin
                chk("resp_wr_allowed", char_fifo_wr_en, (resp_q.size() != 0) && !prev_full);
                if (resp_q.size() != 0) chk("resp_din", char_fifo_din, resp_q.pop_front());
            end
            if (send_resp_done) begin
                chk("done_when_complete", send_resp_done, resp_active && (resp_q.size() == 0));
                done_cnt++;
                done_cyc = cyc;
                resp_active = 0;
            end
            prev_echo = send_char_val;
            prev_chr  = send_char;
            prev_full = char_fifo_full;
        end
    end

    task automatic check_seq(input string name, input byte_q_t exp);
        chk({name, "_len"}, wlog.size(), exp.size());
        for (int i = 0; i < exp.size() && i < wlog.size(); i++) chk(name, wlog[i], exp[i]);
    endtask

    // One request/response handshake with optional directed echo, full window and random noise
    task automatic run_resp(input logic [1:0] t, input logic [15:0] d, input int echo_k,
                            input int full_k, input int full_n, input int hold_extra, input bit rnd);
        int start_done;
        int k;
        bit fin;
        start_done = done_cnt;
        k = 0;
        fin = 0;
        @(posedge clk_rx); #1;
        wlog.delete();
        wcyc.delete();
        send_resp_type = t;
        send_resp_data = d;
        send_resp_val  = 1'b1;
        push_expected(t, d);
        while (!fin) begin
            @(posedge clk_rx); #1;
            k++;
            send_char_val  = (k == echo_k) || (rnd && ($urandom_range(3) == 0));
            send_char      = (k == echo_k) ? 8'h57 : 8'($urandom);
            char_fifo_full = ((k >= full_k) && (k < full_k + full_n)) || (rnd && ($urandom_range(2) == 0));
            if (rnd && k >= 3) begin
                send_resp_type = 2'($urandom);
                send_resp_data = 16'($urandom);
            end
            if (done_cnt != start_done) begin
                fin = 1;
            end else if (k > 400) begin
                chk("resp_timeout", done_cnt, start_done + 1);
                fin = 1;
            end
        end
        send_char_val  = 1'b0;
        char_fifo_full = 1'b0;
        repeat (hold_extra) begin @(posedge clk_rx); #1; end
        chk("single_done", done_cnt, start_done + 1);
        send_resp_val = 1'b0;
        repeat (2) begin @(posedge clk_rx); #1; end
    endtask

    initial begin
        int k;
        int dc;
        rst_clk_rx     = 1'b1;
        send_char_val  = 1'b0;
        send_char      = 8'h00;
        send_resp_val  = 1'b0;
        send_resp_type = 2'b00;
        send_resp_data = 16'h0000;
        char_fifo_full = 1'b0;
        #1;
        chk("init_wr_en", char_fifo_wr_en, 0);
        chk("init_done", send_resp_done, 0);
        repeat (3) @(posedge clk_rx);
        #1 rst_clk_rx = 1'b0;
        repeat (2) begin @(posedge clk_rx); #1; end

        // OK, no stalls: five back-to-back writes, done the cycle after the last
        run_resp(2'b00, 16'h0000, -1, -1, 0, 0, 0);
        check_seq("ok_seq", '{8'h2D, 8'h4F, 8'h4B, 8'h0D, 8'h0A});
        if (wcyc.size() >= 5) begin
            chk("ok_back_to_back", wcyc[4] - wcyc[0], 4);
            chk("ok_done_timing", done_cyc, wcyc[4] + 1);
        end

        // DATA hex conversion
        run_resp(2'b10, 16'hA3F0, -1, -1, 0, 0, 0);
        check_seq("data_seq", '{8'h2D, 8'h41, 8'h33, 8'h46, 8'h30, 8'h0D, 8'h0A});

        // ERR with an echo landing on the third response character
        run_resp(2'b01, 16'h0000, 4, -1, 0, 0, 0);
        check_seq("echo_seq", '{8'h2D, 8'h45, 8'h57, 8'h52, 8'h52, 8'h0D, 8'h0A});

        // OK with full for 4 cycles after the first write
        dc = done_cnt;
        run_resp(2'b00, 16'h0000, -1, 3, 4, 0, 0);
        check_seq("full_seq", '{8'h2D, 8'h4F, 8'h4B, 8'h0D, 8'h0A});
        if (wcyc.size() >= 2) chk("full_gap", wcyc[1] - wcyc[0], 5);
        chk("full_one_done", done_cnt, dc + 1);

        // Type 11 prints as ERR
        run_resp(2'b11, 16'h1234, -1, -1, 0, 0, 0);
        check_seq("t11_seq", '{8'h2D, 8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A});

        // Request held 10 cycles past done, then dropped and re-raised
        run_resp(2'b10, 16'h0B5C, -1, -1, 0, 10, 0);
        check_seq("hold_seq", '{8'h2D, 8'h30, 8'h42, 8'h35, 8'h43, 8'h0D, 8'h0A});
        run_resp(2'b00, 16'h0000, -1, -1, 0, 0, 0);
        check_seq("reraise_seq", '{8'h2D, 8'h4F, 8'h4B, 8'h0D, 8'h0A});

        // Reset after two characters of ERR
        @(posedge clk_rx); #1;
        wlog.delete();
        send_resp_type = 2'b01;
        send_resp_val  = 1'b1;
        push_expected(2'b01, 16'h0000);
        k = 0;
        while (wlog.size() < 2 && k < 50) begin @(posedge clk_rx); #1; k++; end
        chk("rst_two_chars", wlog.size(), 2);
        rst_clk_rx    = 1'b1;
        send_resp_val = 1'b0;
        #1;
        chk("rst_async_wr_en", char_fifo_wr_en, 0);
        chk("rst_async_din", char_fifo_din, 8'h00);
        chk("rst_async_done", send_resp_done, 0);
        repeat (3) begin @(posedge clk_rx); #1; end
        rst_clk_rx = 1'b0;
        wlog.delete();
        repeat (6) begin @(posedge clk_rx); #1; end
        chk("rst_no_writes", wlog.size(), 0);
        run_resp(2'b01, 16'h0000, -1, -1, 0, 0, 0);
        check_seq("post_rst_seq", '{8'h2D, 8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A});

        // Random traffic: echoes, full, input changes during sending, varied hold times
        for (int i = 0; i < 60; i++) begin
            run_resp(2'($urandom), 16'($urandom), -1, -1, 0, int'($urandom_range(3)), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
